// File: rtl/uart_pkg.sv
// Shared frame constants, receive FSM state encoding and the baud divider helper
// for the UART receive path.
package uart_pkg;

   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;

   typedef logic [1:0] rx_state_t;
   localparam rx_state_t ST_IDLE  = 2'd0;
   localparam rx_state_t ST_START = 2'd1;
   localparam rx_state_t ST_DATA  = 2'd2;
   localparam rx_state_t ST_STOP  = 2'd3;

   // Clocks per oversample tick, rounded to nearest.
   function automatic int calc_div(input int clk_hz, input int baud, input int os);
      return (clk_hz + (baud * os) / 2) / (baud * os);
   endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Byte stream from the UART receive FIFO to the bus glue (valid/ready).
interface uart_rx_fifo_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;

   modport master (output rx_data, output rx_valid, input rx_ready);
   modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// First-word-fall-through FIFO; head is read straight from storage, count tells
// full from empty since the pointers wrap modulo DEPTH.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);

   logic [DEPTH-1:0][WIDTH-1:0] mem;
   logic [AW-1:0]               wptr, rptr;
   logic                        do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A pop in the same cycle frees the slot the push is about to use.
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rptr];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mem   <= '0;
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) begin
            mem[wptr] <= din;
            wptr      <= wptr + 1'b1;
         end
         if (do_pop)
            rptr <= rptr + 1'b1;
         if (do_push && !do_pop)
            count <= count + 1'b1;
         else if (do_pop && !do_push)
            count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver: synchroniser, oversample tick gen, 3-sample majority voter,
// framing FSM and a FWFT byte FIFO with frame-error and overrun flags.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int BAUD       = 115_200,
   parameter int OVERSAMPLE = 16,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic                        rx,
   uart_rx_fifo_if.master              bus,
   output logic                        frame_err,
   output logic                        overrun,
   input  logic                        err_clr,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
   localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
   localparam int DW  = $clog2(DIV + 1);
   localparam int SW  = $clog2(OVERSAMPLE);
   localparam int MID = OVERSAMPLE / 2;
   localparam int BW  = $clog2(DATA_BITS);

   logic [1:0]           sync;
   logic                 rxs;
   logic [DW-1:0]        div_cnt;
   logic                 tick;
   rx_state_t            state;
   logic [SW-1:0]        s_cnt;
   logic [BW-1:0]        bit_idx;
   logic [DATA_BITS-1:0] shreg;
   logic [1:0]           smp;
   logic                 maj, mid_tick, s_wrap;
   logic                 idle_ok, start_go;
   logic                 byte_ok, fifo_full, fifo_empty, fifo_pop;

   assign rxs = sync[1];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) sync <= 2'b11;
      else         sync <= {sync[0], rx};
   end

   // Start needs a high tick seen in IDLE, so a held-low line (break) can't re-trigger.
   assign start_go = (state == ST_IDLE) && !rxs && idle_ok;
   assign tick     = (div_cnt == DW'(DIV - 1));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                div_cnt <= '0;
      else if (start_go || tick)  div_cnt <= '0;
      else                        div_cnt <= div_cnt + 1'b1;
   end

   assign mid_tick = tick && (s_cnt == SW'(MID + 1));
   assign s_wrap   = tick && (s_cnt == SW'(OVERSAMPLE - 1));
   assign maj      = (smp[0] & smp[1]) | (smp[0] & rxs) | (smp[1] & rxs);
   assign byte_ok  = (state == ST_STOP) && mid_tick && maj;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= ST_IDLE;
         s_cnt     <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         smp       <= '0;
         idle_ok   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         if (tick && s_cnt == SW'(MID - 1)) smp[0] <= rxs;
         if (tick && s_cnt == SW'(MID))     smp[1] <= rxs;
         if (state != ST_IDLE && tick)
            s_cnt <= s_wrap ? '0 : s_cnt + 1'b1;
         case (state)
            ST_IDLE: begin
               if (tick && rxs) idle_ok <= 1'b1;
               if (start_go) begin
                  state   <= ST_START;
                  s_cnt   <= '0;
                  bit_idx <= '0;
                  idle_ok <= 1'b0;
               end
            end
            ST_START: begin
               if (mid_tick && maj) state <= ST_IDLE;
               else if (s_wrap)     state <= ST_DATA;
            end
            ST_DATA: begin
               if (mid_tick) shreg[bit_idx] <= maj;
               if (s_wrap) begin
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == BW'(DATA_BITS - 1)) state <= ST_STOP;
               end
            end
            default: begin
               // Leave at mid stop bit so the next start edge is never missed.
               if (mid_tick) begin
                  state <= ST_IDLE;
                  if (maj) idle_ok   <= 1'b1;
                  else     frame_err <= 1'b1;
               end
            end
         endcase
      end
   end

   assign fifo_pop = bus.rx_ready & ~fifo_empty;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                             overrun <= 1'b0;
      else if (byte_ok && fifo_full && !fifo_pop) overrun <= 1'b1;
      else if (err_clr)                        overrun <= 1'b0;
   end

   sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (byte_ok),
      .pop    (fifo_pop),
      .din    (shreg),
      .dout   (bus.rx_data),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .count  (fifo_count)
   );

   assign bus.rx_valid = ~fifo_empty;

endmodule
